// File: rtl/pause_aggregator_pkg.sv
// -----------------------------------------------------------------------------
// pause_aggregator_pkg
//   Shared definitions for the pause aggregator:
//     - req_state_e   : request FSM states (IDLE, XOFF_REQ, HOLD, XON_REQ)
//     - XON_QUANTA    : quanta value carried by an XON (resume) request
//     - refresh_cnt_w : width of the XOFF refresh down-counter
// -----------------------------------------------------------------------------
package pause_aggregator_pkg;

    // Request FSM states.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_XOFF_REQ = 2'd1,
        ST_HOLD     = 2'd2,
        ST_XON_REQ  = 2'd3
    } req_state_e;

    // A pause frame with zero quanta tells the link partner to resume.
    localparam int XON_QUANTA = 32'sd0;

    // Width of the refresh counter. The counter holds REFRESH_CYCLES-1 at
    // most, so $clog2(REFRESH_CYCLES) bits suffice; never narrower than 1 bit.
    function automatic int refresh_cnt_w(input int cycles);
        int w;
        if (cycles < 32'sd2) begin
            w = 32'sd1;
        end else begin
            w = $clog2(cycles);
        end
        return w;
    endfunction

endpackage : pause_aggregator_pkg

// File: rtl/pause_aggregator_src_latch.sv
// -----------------------------------------------------------------------------
// pause_src_latch
//   State for one pause source: edge detectors on the pause / unpause request
//   lines, a set/clear latch driven by their rising edges, and a registered
//   copy of the level pause input.
//
// Ports
//   clk_in      : clock
//   rst_in      : synchronous active-high reset
//   pause_in    : pause request; a rising edge sets the latch
//   unpause_in  : unpause request; a rising edge clears the latch
//   level_in    : level pause, registered every cycle
//   active_out  : latch OR registered level (mask is applied by the parent)
// -----------------------------------------------------------------------------
module pause_src_latch (
    input  logic clk_in,
    input  logic rst_in,
    input  logic pause_in,
    input  logic unpause_in,
    input  logic level_in,
    output logic active_out
);

    logic pause_q;
    logic unpause_q;
    logic latch_q;
    logic latch_d;
    logic level_q;
    logic set_s;
    logic clr_s;

    // Rising-edge detection and latch next-state; simultaneous set and
    // clear cancel each other so the latch keeps its value.
    always_comb begin
        set_s   = pause_in & ~pause_q;
        clr_s   = unpause_in & ~unpause_q;
        latch_d = latch_q;
        if (set_s && !clr_s) begin
            latch_d = 1'b1;
        end else if (clr_s && !set_s) begin
            latch_d = 1'b0;
        end else begin
            latch_d = latch_q;
        end
    end

    // Edge history, latch and level registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pause_q   <= 1'b0;
            unpause_q <= 1'b0;
            latch_q   <= 1'b0;
            level_q   <= 1'b0;
        end else begin
            pause_q   <= pause_in;
            unpause_q <= unpause_in;
            latch_q   <= latch_d;
            level_q   <= level_in;
        end
    end

    assign active_out = latch_q | level_q;

endmodule : pause_src_latch

// File: rtl/pause_aggregator.sv
// -----------------------------------------------------------------------------
// pause_aggregator
//   Merges NUM_SRC pause sources into one aggregate pause state and turns
//   changes of that state into XOFF / XON requests towards the pause-frame
//   injector over a valid/ready handshake.
//
// Build option
//   PAUSE_AGG_REFRESH_EN : when defined, XOFF is re-issued every
//                          REFRESH_CYCLES cycles while pause persists. When
//                          undefined no refresh counter exists and one XOFF
//                          is sent per pause episode.
//
// Ports
//   clk_in            : clock
//   rst_in            : synchronous active-high reset
//   pause_in          : per-source pause request (rising edge sets latch)
//   unpause_in        : per-source unpause request (rising edge clears latch)
//   pause_unpause_in  : per-source level pause (registered)
//   src_mask_in       : per-source mask, 1 = excluded from the aggregate
//   quanta_in         : quanta captured for each XOFF request
//   pause_active_out  : per-source state, before masking
//   inject_pause_out  : aggregate pause (OR of unmasked sources)
//   req_valid_out     : request valid
//   req_ready_in      : injector accepts request
//   req_quanta_out    : quanta of pending request, 0 means XON
// -----------------------------------------------------------------------------
module pause_aggregator
    import pause_aggregator_pkg::*;
#(
    parameter int NUM_SRC        = 4,
    parameter int QUANTA_W       = 16,
    parameter int REFRESH_CYCLES = 1024
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic [NUM_SRC-1:0]  pause_in,
    input  logic [NUM_SRC-1:0]  unpause_in,
    input  logic [NUM_SRC-1:0]  pause_unpause_in,
    input  logic [NUM_SRC-1:0]  src_mask_in,
    input  logic [QUANTA_W-1:0] quanta_in,
    output logic [NUM_SRC-1:0]  pause_active_out,
    output logic                inject_pause_out,
    output logic                req_valid_out,
    input  logic                req_ready_in,
    output logic [QUANTA_W-1:0] req_quanta_out
);

    localparam logic [QUANTA_W-1:0] XON_Q = QUANTA_W'(XON_QUANTA);

    req_state_e          state_q;
    req_state_e          state_d;
    logic [QUANTA_W-1:0] quanta_q;
    logic [QUANTA_W-1:0] quanta_d;
    logic                accept_s;

    // ------------------------------------------------------------------
    // Per-source state
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        pause_src_latch u_src (
            .clk_in     (clk_in),
            .rst_in     (rst_in),
            .pause_in   (pause_in[gi]),
            .unpause_in (unpause_in[gi]),
            .level_in   (pause_unpause_in[gi]),
            .active_out (pause_active_out[gi])
        );
    end

    // The mask acts combinationally so masking takes effect in the same cycle.
    assign inject_pause_out = |(pause_active_out & ~src_mask_in);

    assign accept_s = req_valid_out & req_ready_in;

`ifdef PAUSE_AGG_REFRESH_EN
    localparam int                CNT_W    = refresh_cnt_w(REFRESH_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
`endif

    // Request FSM next-state and outputs. A request is held unchanged until
    // accepted; aggregate changes seen meanwhile are handled afterwards.
    always_comb begin
        state_d        = state_q;
        quanta_d       = quanta_q;
        req_valid_out  = 1'b0;
        req_quanta_out = XON_Q;
`ifdef PAUSE_AGG_REFRESH_EN
        cnt_d          = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (inject_pause_out) begin
                    state_d  = ST_XOFF_REQ;
                    quanta_d = quanta_in;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_XOFF_REQ: begin
                req_valid_out  = 1'b1;
                req_quanta_out = quanta_q;
                if (accept_s) begin
                    if (inject_pause_out) begin
                        state_d = ST_HOLD;
`ifdef PAUSE_AGG_REFRESH_EN
                        cnt_d   = CNT_LOAD;
`endif
                    end else begin
                        state_d = ST_XON_REQ;
                    end
                end else begin
                    state_d = ST_XOFF_REQ;
                end
            end
            ST_HOLD: begin
                if (!inject_pause_out) begin
                    state_d = ST_XON_REQ;
                end else begin
`ifdef PAUSE_AGG_REFRESH_EN
                    // Counter saturates at zero; zero triggers a refresh XOFF.
                    if (cnt_q == CNT_ZERO) begin
                        state_d  = ST_XOFF_REQ;
                        quanta_d = quanta_in;
                    end else begin
                        cnt_d    = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
`else
                    state_d = ST_HOLD;
`endif
                end
            end
            ST_XON_REQ: begin
                req_valid_out  = 1'b1;
                req_quanta_out = XON_Q;
                if (accept_s) begin
                    if (inject_pause_out) begin
                        state_d  = ST_XOFF_REQ;
                        quanta_d = quanta_in;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end else begin
                    state_d = ST_XON_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state and captured quanta registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= ST_IDLE;
            quanta_q <= {QUANTA_W{1'b0}};
        end else begin
            state_q  <= state_d;
            quanta_q <= quanta_d;
        end
    end

`ifdef PAUSE_AGG_REFRESH_EN
    // Refresh counter register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_q <= CNT_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

endmodule : pause_aggregator

// File: tb/tb_pause_aggregator.sv
// -----------------------------------------------------------------------------
// tb_pause_aggregator
//   Directed scenarios followed by randomized stimulus; every cycle the DUT
//   outputs are compared against a frame-level reference model that tracks
//   which pause state was last announced to the injector.
// -----------------------------------------------------------------------------
module tb_pause_aggregator;

    localparam int NUM_SRC  = 4;
    localparam int QUANTA_W = 16;
    localparam int REFRESH  = 8;

    logic                clk;
    logic                rst_in;
    logic [NUM_SRC-1:0]  pause_in;
    logic [NUM_SRC-1:0]  unpause_in;
    logic [NUM_SRC-1:0]  pause_unpause_in;
    logic [NUM_SRC-1:0]  src_mask_in;
    logic [QUANTA_W-1:0] quanta_in;
    logic [NUM_SRC-1:0]  pause_active_out;
    logic                inject_pause_out;
    logic                req_valid_out;
    logic                req_ready_in;
    logic [QUANTA_W-1:0] req_quanta_out;

    int n_checks = 0;
    int n_errors = 0;
    bit checks_on = 1'b0;
    int xoff_seen = 0;

    // Reference model state
    bit [NUM_SRC-1:0]  m_prev_p;
    bit [NUM_SRC-1:0]  m_prev_u;
    bit [NUM_SRC-1:0]  m_latch;
    bit [NUM_SRC-1:0]  m_level;
    bit                m_pend;      // a request is outstanding
    bit                m_is_xoff;   // outstanding request kind
    bit [QUANTA_W-1:0] m_pq;        // outstanding request quanta
    bit                m_announced; // last accepted frame was XOFF
    int                m_hold;      // cycles spent paused with nothing pending

    pause_aggregator #(
        .NUM_SRC        (NUM_SRC),
        .QUANTA_W       (QUANTA_W),
        .REFRESH_CYCLES (REFRESH)
    ) dut (
        .clk_in           (clk),
        .rst_in           (rst_in),
        .pause_in         (pause_in),
        .unpause_in       (unpause_in),
        .pause_unpause_in (pause_unpause_in),
        .src_mask_in      (src_mask_in),
        .quanta_in        (quanta_in),
        .pause_active_out (pause_active_out),
        .inject_pause_out (inject_pause_out),
        .req_valid_out    (req_valid_out),
        .req_ready_in     (req_ready_in),
        .req_quanta_out   (req_quanta_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit [NUM_SRC-1:0] model_active();
        return m_latch | m_level;
    endfunction

    function automatic bit model_agg();
        return |(model_active() & ~src_mask_in);
    endfunction

    task automatic model_issue(input bit xoff);
        m_pend    = 1'b1;
        m_is_xoff = xoff;
        m_pq      = xoff ? quanta_in : '0;
    endtask

    // Advance the model across one clock edge using the current inputs.
    task automatic model_update();
        bit agg;
        bit was_free;
        if (rst_in) begin
            m_prev_p = '0; m_prev_u = '0; m_latch = '0; m_level = '0;
            m_pend = 1'b0; m_is_xoff = 1'b0; m_pq = '0;
            m_announced = 1'b0; m_hold = 0;
        end else begin
            agg      = model_agg();
            was_free = !m_pend;
            if (m_pend && req_ready_in) begin
                m_pend      = 1'b0;
                m_announced = m_is_xoff;
                m_hold      = 0;
            end
            if (!m_pend) begin
                if (!m_announced && agg) begin
                    model_issue(1'b1);
                end else if (m_announced && !agg) begin
                    model_issue(1'b0);
                end else if (m_announced && agg && was_free) begin
`ifdef PAUSE_AGG_REFRESH_EN
                    m_hold++;
                    if (m_hold == REFRESH) begin
                        model_issue(1'b1);
                        m_hold = 0;
                    end
`endif
                end
            end
            for (int i = 0; i < NUM_SRC; i++) begin
                bit s;
                bit c;
                s = pause_in[i] && !m_prev_p[i];
                c = unpause_in[i] && !m_prev_u[i];
                if (s && !c) m_latch[i] = 1'b1;
                else if (c && !s) m_latch[i] = 1'b0;
            end
            m_prev_p = pause_in;
            m_prev_u = unpause_in;
            m_level  = pause_unpause_in;
        end
    endtask

    // One clock cycle: inputs were set just after a falling edge; compare,
    // advance the model, and return after the next falling edge.
    task automatic step();
        #1;
        if (checks_on) begin
            chk("active", pause_active_out, model_active());
            chk("inject", inject_pause_out, model_agg());
            chk("valid",  req_valid_out,    m_pend);
            chk("quanta", req_quanta_out,   m_pend ? m_pq : '0);
        end
        if (req_valid_out && req_ready_in && req_quanta_out != '0) xoff_seen++;
        model_update();
        @(negedge clk);
    endtask

    initial begin
        int exp_xoff;
        rst_in = 1'b1; pause_in = '0; unpause_in = '0; pause_unpause_in = '0;
        src_mask_in = '0; quanta_in = '0; req_ready_in = 1'b0;
        @(negedge clk);
        step();
        step();
        checks_on = 1'b1;
        chk("rst_active", pause_active_out, 0);
        chk("rst_inject", inject_pause_out, 0);
        chk("rst_valid",  req_valid_out, 0);
        chk("rst_quanta", req_quanta_out, 0);
        rst_in = 1'b0;
        step();

        // Source 0 edge pause, XOFF accepted immediately
        req_ready_in = 1'b1; quanta_in = 16'h00FF; pause_in = 4'b0001;
        step();
        chk("s1_active0", pause_active_out[0], 1);
        chk("s1_inject", inject_pause_out, 1);
        step();
        chk("s1_valid", req_valid_out, 1);
        chk("s1_quanta", req_quanta_out, 16'h00FF);
        step();
        chk("s1_hold_valid", req_valid_out, 0);

        // Unpause edge -> XON then idle
        unpause_in = 4'b0001;
        step();
        chk("s2_inject", inject_pause_out, 0);
        step();
        chk("s2_xon_valid", req_valid_out, 1);
        chk("s2_xon_quanta", req_quanta_out, 0);
        step();
        chk("s2_idle_valid", req_valid_out, 0);
        pause_in = '0; unpause_in = '0;
        step();

        // Simultaneous set and clear edges cancel
        pause_in = 4'b0010; unpause_in = 4'b0010;
        step();
        chk("s3_active1", pause_active_out[1], 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("s3_valid", req_valid_out, 0);
        end
        pause_in = '0; unpause_in = '0;
        step();

        // Masked level source: active but not aggregated
        src_mask_in = 4'b0100; pause_unpause_in = 4'b0100;
        step();
        chk("s4_active2", pause_active_out[2], 1);
        chk("s4_inject", inject_pause_out, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("s4_valid", req_valid_out, 0);
        end
        pause_unpause_in = '0;
        step();
        step();
        src_mask_in = '0;
        step();

        // Persistent level pause: refresh behaviour
        quanta_in = 16'h1234; xoff_seen = 0; pause_unpause_in = 4'b1000;
        for (int i = 0; i < 30; i++) begin
            if (i == 15) quanta_in = 16'h0ABC;
            step();
        end
`ifdef PAUSE_AGG_REFRESH_EN
        exp_xoff = 4;
`else
        exp_xoff = 1;
`endif
        chk("s5_xoff_count", xoff_seen, exp_xoff);
        pause_unpause_in = '0;
        for (int i = 0; i < 12; i++) step();
        chk("s5_idle_valid", req_valid_out, 0);

        // Backpressure while the aggregate drops, then reset during XON
        quanta_in = 16'h00AA; req_ready_in = 1'b0; pause_unpause_in = 4'b0001;
        step();
        step();
        pause_unpause_in = '0; quanta_in = 16'h5555;
        for (int i = 0; i < 5; i++) begin
            chk("s6_hold_valid", req_valid_out, 1);
            chk("s6_hold_quanta", req_quanta_out, 16'h00AA);
            step();
        end
        req_ready_in = 1'b1;
        chk("s6_accept_valid", req_valid_out, 1);
        step();
        chk("s6_xon_valid", req_valid_out, 1);
        chk("s6_xon_quanta", req_quanta_out, 0);
        req_ready_in = 1'b0;
        step();
        rst_in = 1'b1;
        step();
        chk("s6_rst_valid", req_valid_out, 0);
        rst_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("s6_no_xon", req_valid_out, 0);
        end

        // Randomized traffic
        for (int c = 0; c < 2000; c++) begin
            pause_in   = pause_in ^ NUM_SRC'($urandom & $urandom);
            unpause_in = unpause_in ^ NUM_SRC'($urandom & $urandom);
            if ($urandom_range(7, 0) == 0) pause_unpause_in = NUM_SRC'($urandom & $urandom);
            if ($urandom_range(15, 0) == 0) src_mask_in = NUM_SRC'($urandom & $urandom);
            if ($urandom_range(9, 0) == 0) quanta_in = QUANTA_W'($urandom);
            req_ready_in = ($urandom_range(2, 0) != 0);
            rst_in = ($urandom_range(299, 0) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_pause_aggregator
